// File: rtl/instr_loader.sv
// Program loader: streams bytes into 32-bit words for instruction memory,
// holds the CPU in reset while loading and verifies a trailing XOR checksum.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] LEN,
  input  logic [7:0]        DIN,
  input  logic              DIN_VLD,
  output logic              DIN_RDY,
  output logic              WE,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [31:0]       W_Ins,
  output logic              CPU_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, CHK, FIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wins_q, wins_d;
  logic              err_q, err_d;
  logic              hs;

  assign DIN_RDY  = (state_q == RECV) || (state_q == CHK);
  assign BUSY     = DIN_RDY || (state_q == WRITE);
  assign CPU_HOLD = BUSY;
  assign WE       = (state_q == WRITE);
  assign DONE     = (state_q == FIN);
  assign ERR      = err_q;
  assign W_ADDR   = waddr_q;
  assign W_Ins    = wins_q;
  assign hs       = DIN_VLD && DIN_RDY;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    wins_d  = wins_q;
    err_d   = err_q;
    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          len_d   = LEN;
          idx_d   = '0;
          bcnt_d  = '0;
          csum_d  = '0;
          err_d   = 1'b0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (hs) begin
          csum_d = csum_q ^ DIN;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Output regs load here so they hold while the next word builds
            wins_d  = {DIN, word_q};
            waddr_d = idx_q;
            state_d = WRITE;
          end else begin
            word_d[{bcnt_q, 3'b000} +: 8] = DIN;
          end
        end
      end
      WRITE: begin
        if (idx_q == len_q) begin
          state_d = CHK;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RECV;
        end
      end
      CHK: begin
        if (hs) begin
          err_d   = (DIN != csum_q);
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      csum_q  <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      wins_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      csum_q  <= csum_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      wins_q  <= wins_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: byte streams with gaps, checksum
// errors, ignored START/DIN_VLD, mid-load reset and a full-depth load.
module tb_instr_loader;

  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic [AW-1:0] LEN = '0;
  logic [7:0]    DIN = '0;
  logic          DIN_VLD = 1'b0;
  logic          DIN_RDY, WE, CPU_HOLD, BUSY, DONE, ERR;
  logic [AW-1:0] W_ADDR;
  logic [31:0]   W_Ins;

  instr_loader #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN),
    .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY),
    .WE(WE), .W_ADDR(W_ADDR), .W_Ins(W_Ins),
    .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;
  int we_cnt = 0;
  logic [7:0] bq[$];

  always @(negedge CLK) if (WE) we_cnt++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        DIN_VLD = 1'b0;
        DIN = 8'($urandom);
        @(negedge CLK);
      end
    end
    DIN = b;
    DIN_VLD = 1'b1;
    n = 0;
    while (!DIN_RDY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) check("rdy_timeout", 32'(DIN_RDY), 32'd1);
    @(negedge CLK);
    DIN_VLD = 1'b0;
  endtask

  // bq holds the whole program; expectations come from packing and XOR.
  task automatic run_load(input int len, input bit gaps, input int csum_in,
                          input bit poke, input int abort_at);
    logic [7:0]  cs, cb;
    logic [31:0] w;
    int base, nb;
    cs = '0;
    foreach (bq[i]) cs ^= bq[i];
    cb = (csum_in < 0) ? cs : csum_in[7:0];
    if (poke) begin
      DIN_VLD = 1'b1;
      repeat (3) begin
        DIN = 8'($urandom);
        @(negedge CLK);
      end
      check("idle_busy", 32'(BUSY), 32'd0);
    end
    DIN_VLD = 1'b0;
    START = 1'b1;
    LEN = AW'(len);
    @(negedge CLK);
    START = 1'b0;
    LEN = AW'($urandom);
    check("start_busy", 32'(BUSY), 32'd1);
    check("start_hold", 32'(CPU_HOLD), 32'd1);
    check("start_done", 32'(DONE), 32'd0);
    check("start_err", 32'(ERR), 32'd0);
    check("start_rdy", 32'(DIN_RDY), 32'd1);
    base = we_cnt;
    nb = 0;
    for (int wi = 0; wi <= len; wi++) begin
      for (int k = 0; k < 4; k++) begin
        if (nb == abort_at) begin
          RST = 1'b0;
          #1;
          check("rst_we", 32'(WE), 32'd0);
          check("rst_rdy", 32'(DIN_RDY), 32'd0);
          check("rst_hold", 32'(CPU_HOLD), 32'd0);
          check("rst_busy", 32'(BUSY), 32'd0);
          check("rst_done", 32'(DONE), 32'd0);
          check("rst_err", 32'(ERR), 32'd0);
          check("rst_waddr", 32'(W_ADDR), 32'd0);
          check("rst_wins", W_Ins, 32'd0);
          DIN_VLD = 1'b1;
          repeat (3) @(negedge CLK);
          DIN_VLD = 1'b0;
          check("rst_wecnt", 32'(we_cnt - base), 32'(nb / 4));
          return;
        end
        if (poke && nb == 2) begin
          START = 1'b1;
          @(negedge CLK);
          START = 1'b0;
        end
        send_byte(bq[nb], gaps);
        nb++;
      end
      w = {bq[nb-1], bq[nb-2], bq[nb-3], bq[nb-4]};
      check("we", 32'(WE), 32'd1);
      check("waddr", 32'(W_ADDR), 32'(wi));
      check("wins", W_Ins, w);
    end
    send_byte(cb, gaps);
    check("fin_done", 32'(DONE), 32'd1);
    check("fin_err", 32'(ERR), 32'(cb != cs));
    check("fin_hold", 32'(CPU_HOLD), 32'd0);
    check("fin_busy", 32'(BUSY), 32'd0);
    check("fin_wecnt", 32'(we_cnt - base), 32'(len + 1));
    check("fin_waddr", 32'(W_ADDR), 32'(len));
    check("fin_wins", W_Ins, w);
    DIN_VLD = 1'b1;
    repeat (3) begin
      DIN = 8'($urandom);
      @(negedge CLK);
    end
    DIN_VLD = 1'b0;
    check("keep_done", 32'(DONE), 32'd1);
    check("keep_err", 32'(ERR), 32'(cb != cs));
    check("keep_wecnt", 32'(we_cnt - base), 32'(len + 1));
  endtask

  task automatic fill_rand(input int len);
    bq.delete();
    for (int i = 0; i < (len + 1) * 4; i++) bq.push_back(8'($urandom));
  endtask

  initial begin
    #2;
    check("r_we", 32'(WE), 32'd0);
    check("r_rdy", 32'(DIN_RDY), 32'd0);
    check("r_hold", 32'(CPU_HOLD), 32'd0);
    check("r_busy", 32'(BUSY), 32'd0);
    check("r_done", 32'(DONE), 32'd0);
    check("r_err", 32'(ERR), 32'd0);
    check("r_waddr", 32'(W_ADDR), 32'd0);
    check("r_wins", W_Ins, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    bq = '{8'h20, 8'h00, 8'h08, 8'h01};
    run_load(0, 1'b0, -1, 1'b0, -1);
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'(i));
    run_load(2, 1'b1, -1, 1'b0, -1);
    bq = '{8'h20, 8'h00, 8'h08, 8'h01};
    run_load(0, 1'b0, 0, 1'b0, -1);
    fill_rand(3);
    run_load(3, 1'b1, -1, 1'b1, -1);
    fill_rand(2);
    run_load(2, 1'b1, -1, 1'b0, 6);
    RST = 1'b1;
    fill_rand(1);
    run_load(1, 1'b0, -1, 1'b0, -1);
    fill_rand(15);
    run_load(15, 1'b1, -1, 1'b0, -1);
    for (int t = 0; t < 6; t++) begin
      int l;
      l = $urandom_range(0, 5);
      fill_rand(l);
      run_load(l, 1'($urandom), $urandom_range(0, 1) ? -1
               : int'($urandom_range(0, 255)), 1'($urandom), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
